// File: rtl/bp_btb.sv
// bp_btb: PC-indexed branch target buffer for the IF stage.
//
// Each entry holds a valid bit, a tag, a target and a 2-bit direction counter.
// The lookup is combinational from if_pc. EX-stage resolutions update the table
// on the clock edge. A misprediction raises a one-cycle registered flush
// together with the corrected fetch PC.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   if_pc             fetch PC to look up
//   pred_hit          entry valid and tag matches
//   pred_taken        predicted taken (hit and counter MSB set)
//   pred_target       predicted next fetch PC (stored target or if_pc+4)
//   ex_valid          resolved control-flow instruction present in EX
//   ex_pc             PC of the resolved instruction
//   ex_taken          actual direction
//   ex_target         actual taken target
//   ex_pred_taken     direction predicted for this instruction
//   ex_pred_target    next PC predicted for this instruction
//   flush             one-cycle mispredict pulse, one cycle after EX
//   redirect_pc       corrected next PC, valid while flush=1
//   branch_cnt        saturating count of resolved branches
//   mispred_cnt       saturating count of mispredictions
module bp_btb #(
   parameter int XLEN    = 32,
   parameter int ENTRIES = 16,
   parameter int IDX_W   = $clog2(ENTRIES),
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [XLEN-1:0]  if_pc,
   output logic             pred_hit,
   output logic             pred_taken,
   output logic [XLEN-1:0]  pred_target,
   input  logic             ex_valid,
   input  logic [XLEN-1:0]  ex_pc,
   input  logic             ex_taken,
   input  logic [XLEN-1:0]  ex_target,
   input  logic             ex_pred_taken,
   input  logic [XLEN-1:0]  ex_pred_target,
   output logic             flush,
   output logic [XLEN-1:0]  redirect_pc,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] mispred_cnt
);

   localparam int TAG_W = XLEN - IDX_W - 2;

   // Direction counter encoding
   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] WT  = 2'b10;
   localparam logic [1:0] ST  = 2'b11;

   // Storage array
   logic             valid_q [ENTRIES];
   logic [TAG_W-1:0] tag_q   [ENTRIES];
   logic [XLEN-1:0]  tgt_q   [ENTRIES];
   logic [1:0]       cnt_q   [ENTRIES];

   logic             flush_q, flush_d;
   logic [XLEN-1:0]  redirect_q, redirect_d;
   logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
   logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

   // Saturating increment: holds at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // 2-bit direction counter. Note the asymmetry: a taken outcome from WNT
   // jumps straight to ST, and any not-taken outcome below ST drops to SNT.
   function automatic logic [1:0] cnt_next(input logic [1:0] c, input logic taken);
      logic [1:0] n;
      unique case (c)
         SNT:     n = taken ? WNT : SNT;
         WNT:     n = taken ? ST  : SNT;
         WT:      n = taken ? ST  : SNT;
         default: n = taken ? ST  : WT;
      endcase
      return n;
   endfunction

   // Lookup side
   logic [IDX_W-1:0] l_idx;
   logic [TAG_W-1:0] l_tag;

   assign l_idx = if_pc[IDX_W+1:2];
   assign l_tag = if_pc[XLEN-1:IDX_W+2];

   always_comb begin
      pred_hit    = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
      pred_taken  = pred_hit && cnt_q[l_idx][1];
      pred_target = pred_taken ? tgt_q[l_idx] : if_pc + XLEN'(4);
   end

   // Update side
   logic [IDX_W-1:0] u_idx;
   logic [TAG_W-1:0] u_tag;
   logic             u_hit;
   logic             mis;

   assign u_idx = ex_pc[IDX_W+1:2];
   assign u_tag = ex_pc[XLEN-1:IDX_W+2];

   // The two low PC bits never participate in indexing or tagging.
   logic unused_pc_lsbs;
   assign unused_pc_lsbs = ^{if_pc[1:0], ex_pc[1:0]};

   always_comb begin
      u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
      mis   = ex_valid && ((ex_pred_taken != ex_taken) ||
                           (ex_taken && (ex_pred_target != ex_target)));

      flush_d       = mis;
      redirect_d    = redirect_q;
      branch_cnt_d  = branch_cnt_q;
      mispred_cnt_d = mispred_cnt_q;

      if (mis) begin
         redirect_d    = ex_taken ? ex_target : ex_pc + XLEN'(4);
         mispred_cnt_d = sat_inc(mispred_cnt_q);
      end
      if (ex_valid) begin
         branch_cnt_d = sat_inc(branch_cnt_q);
      end
   end

   // Table write: a hit trains the entry; a taken miss allocates it, evicting
   // any alias; a not-taken miss leaves the table alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            tag_q[i]   <= '0;
            tgt_q[i]   <= '0;
            cnt_q[i]   <= SNT;
         end
      end else if (ex_valid) begin
         if (u_hit) begin
            cnt_q[u_idx] <= cnt_next(cnt_q[u_idx], ex_taken);
            if (ex_taken) begin
               tgt_q[u_idx] <= ex_target;
            end
         end else if (ex_taken) begin
            valid_q[u_idx] <= 1'b1;
            tag_q[u_idx]   <= u_tag;
            tgt_q[u_idx]   <= ex_target;
            cnt_q[u_idx]   <= WNT;
         end
      end
   end

   // EX -> IF redirect stage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flush_q       <= 1'b0;
         redirect_q    <= '0;
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else begin
         flush_q       <= flush_d;
         redirect_q    <= redirect_d;
         branch_cnt_q  <= branch_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

   assign flush       = flush_q;
   assign redirect_pc = redirect_q;
   assign branch_cnt  = branch_cnt_q;
   assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_bp_btb.sv
module tb_bp_btb;

   localparam int XLEN    = 32;
   localparam int ENTRIES = 16;
   localparam int CNT_W   = 4;
   localparam int CMAX    = 15;

   logic             clk = 1'b0;
   logic             rst;
   logic [XLEN-1:0]  if_pc;
   logic             pred_hit;
   logic             pred_taken;
   logic [XLEN-1:0]  pred_target;
   logic             ex_valid;
   logic [XLEN-1:0]  ex_pc;
   logic             ex_taken;
   logic [XLEN-1:0]  ex_target;
   logic             ex_pred_taken;
   logic [XLEN-1:0]  ex_pred_target;
   logic             flush;
   logic [XLEN-1:0]  redirect_pc;
   logic [CNT_W-1:0] branch_cnt;
   logic [CNT_W-1:0] mispred_cnt;

   int tests = 0;
   int errs  = 0;

   bp_btb #(.XLEN(XLEN), .ENTRIES(ENTRIES), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .if_pc(if_pc),
      .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
      .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
      .flush(flush), .redirect_pc(redirect_pc),
      .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: table kept as plain arrays, counter as a 0..3 level.
   bit              m_v   [ENTRIES];
   logic [XLEN-1:0] m_tag [ENTRIES];
   logic [XLEN-1:0] m_tgt [ENTRIES];
   int              m_cnt [ENTRIES];
   logic            m_flush;
   logic [XLEN-1:0] m_redir;
   int              m_bc, m_mc;

   task automatic m_reset();
      for (int i = 0; i < ENTRIES; i++) begin
         m_v[i] = 0; m_tag[i] = '0; m_tgt[i] = '0; m_cnt[i] = 0;
      end
      m_flush = 0; m_redir = '0; m_bc = 0; m_mc = 0;
   endtask

   task automatic m_look(input logic [XLEN-1:0] pc, output logic h, output logic t,
                         output logic [XLEN-1:0] tg);
      int i;
      i  = int'((pc >> 2) % ENTRIES);
      h  = m_v[i] && (m_tag[i] == (pc >> 6));
      t  = h && (m_cnt[i] >= 2);
      tg = t ? m_tgt[i] : pc + 32'd4;
   endtask

   // Applies the current EX inputs to the model as the coming edge would.
   task automatic m_step();
      logic mis;
      int   u;
      bit   h;
      mis = ex_valid && ((ex_pred_taken != ex_taken) || (ex_taken && ex_pred_target != ex_target));
      m_flush = mis;
      if (mis) begin
         m_redir = ex_taken ? ex_target : ex_pc + 32'd4;
         if (m_mc < CMAX) m_mc++;
      end
      if (ex_valid) begin
         if (m_bc < CMAX) m_bc++;
         u = int'((ex_pc >> 2) % ENTRIES);
         h = m_v[u] && (m_tag[u] == (ex_pc >> 6));
         if (h) begin
            if (ex_taken) m_cnt[u] = (m_cnt[u] == 0) ? 1 : 3;
            else          m_cnt[u] = (m_cnt[u] == 3) ? 2 : 0;
            if (ex_taken) m_tgt[u] = ex_target;
         end else if (ex_taken) begin
            m_v[u] = 1; m_tag[u] = ex_pc >> 6; m_tgt[u] = ex_target; m_cnt[u] = 1;
         end
      end
   endtask

   function automatic logic [XLEN-1:0] gen_pc();
      logic [XLEN-1:0] tg;
      case ($urandom_range(0, 2))
         0:       tg = 32'd0;
         1:       tg = 32'd1;
         default: tg = 32'h03FF_FFFF;
      endcase
      return (tg << 6) | (XLEN'($urandom_range(0, 15)) << 2) | XLEN'($urandom_range(0, 3));
   endfunction

   task automatic set_ex(input logic v, input logic [31:0] pc, input logic tk,
                         input logic [31:0] tg, input logic pt, input logic [31:0] ptg);
      ex_valid = v; ex_pc = pc; ex_taken = tk; ex_target = tg;
      ex_pred_taken = pt; ex_pred_target = ptg;
   endtask

   typedef struct {
      logic        ev;
      logic [31:0] pc;
      logic        tk;
      logic [31:0] tgt;
      logic        pt;
      logic [31:0] ptg;
      logic [31:0] ifpc;
      logic        xf;
      logic [31:0] xr;
      logic        xh;
      logic        xpt;
      logic [31:0] xptg;
   } vec_t;

   vec_t tbl [14];

   initial begin
      logic h, t;
      logic [XLEN-1:0] tg;

      tbl[0]  = '{1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104, 32'h100, 1'b1, 32'h200, 1'b1, 1'b0, 32'h104};
      tbl[1]  = '{1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104, 32'h100, 1'b1, 32'h200, 1'b1, 1'b1, 32'h200};
      tbl[2]  = '{1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200, 32'h100, 1'b0, 32'h200, 1'b1, 1'b1, 32'h200};
      tbl[3]  = '{1'b1, 32'h100, 1'b0, 32'h0,   1'b1, 32'h200, 32'h100, 1'b1, 32'h104, 1'b1, 1'b1, 32'h200};
      tbl[4]  = '{1'b1, 32'h100, 1'b0, 32'h0,   1'b1, 32'h200, 32'h100, 1'b1, 32'h104, 1'b1, 1'b0, 32'h104};
      tbl[5]  = '{1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104, 32'h100, 1'b1, 32'h200, 1'b1, 1'b0, 32'h104};
      tbl[6]  = '{1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104, 32'h100, 1'b1, 32'h200, 1'b1, 1'b1, 32'h200};
      tbl[7]  = '{1'b1, 32'h100, 1'b1, 32'h300, 1'b1, 32'h200, 32'h100, 1'b1, 32'h300, 1'b1, 1'b1, 32'h300};
      tbl[8]  = '{1'b0, 32'h100, 1'b0, 32'h0,   1'b0, 32'h0,   32'h100, 1'b0, 32'h300, 1'b1, 1'b1, 32'h300};
      tbl[9]  = '{1'b1, 32'h140, 1'b1, 32'h500, 1'b0, 32'h144, 32'h100, 1'b1, 32'h500, 1'b0, 1'b0, 32'h104};
      tbl[10] = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   32'h140, 1'b0, 32'h500, 1'b1, 1'b0, 32'h144};
      tbl[11] = '{1'b1, 32'h180, 1'b0, 32'h0,   1'b0, 32'h184, 32'h140, 1'b0, 32'h500, 1'b1, 1'b0, 32'h144};
      tbl[12] = '{1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h1234, 32'hFFFF_FFFC, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0};
      tbl[13] = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   32'h100, 1'b0, 32'h0,   1'b0, 1'b0, 32'h104};

      // Reset state
      rst = 1'b1; if_pc = 32'h100;
      set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      #12 rst = 1'b0;
      #1;
      chk("rst_hit", pred_hit, 0);
      chk("rst_ptaken", pred_taken, 0);
      chk("rst_ptarget", pred_target, 32'h104);
      chk("rst_flush", flush, 0);
      chk("rst_redir", redirect_pc, 0);
      chk("rst_bcnt", branch_cnt, 0);
      chk("rst_mcnt", mispred_cnt, 0);
      @(posedge clk); #1;

      // Directed table: allocation, counter walk, target mismatch, alias, wrap
      for (int i = 0; i < 14; i++) begin
         set_ex(tbl[i].ev, tbl[i].pc, tbl[i].tk, tbl[i].tgt, tbl[i].pt, tbl[i].ptg);
         @(posedge clk); #1;
         chk($sformatf("tbl%0d_flush", i), flush, tbl[i].xf);
         chk($sformatf("tbl%0d_redir", i), redirect_pc, tbl[i].xr);
         set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
         if_pc = tbl[i].ifpc;
         #1;
         chk($sformatf("tbl%0d_hit", i), pred_hit, tbl[i].xh);
         chk($sformatf("tbl%0d_ptaken", i), pred_taken, tbl[i].xpt);
         chk($sformatf("tbl%0d_ptarget", i), pred_target, tbl[i].xptg);
      end
      // 11 resolved branches, 9 of them mispredicted, both under 15
      chk("tbl_bcnt", branch_cnt, 11);
      chk("tbl_mcnt", mispred_cnt, 9);

      // Async reset with a mispredict pending and a live entry at 0x140
      set_ex(1'b1, 32'h140, 1'b0, 32'h0, 1'b1, 32'h500);
      @(posedge clk); #1;
      chk("pre_rst_flush", flush, 1);
      if_pc = 32'h100;
      set_ex(1'b1, 32'h100, 1'b1, 32'h700, 1'b0, 32'h104);
      #1 rst = 1'b1;
      #1;
      chk("arst_flush", flush, 0);
      chk("arst_redir", redirect_pc, 0);
      chk("arst_bcnt", branch_cnt, 0);
      chk("arst_mcnt", mispred_cnt, 0);
      chk("arst_ptarget", pred_target, 32'h104);
      if_pc = 32'h140;
      #1;
      chk("arst_hit", pred_hit, 0);
      chk("arst_ptaken", pred_taken, 0);
      rst = 1'b0;
      if_pc = 32'h100;
      // First edge after release performs the pending allocation of 0x100;
      // the same-cycle lookup must still see the empty entry.
      chk("nobypass_hit", pred_hit, 0);
      @(posedge clk); #1;
      chk("post_rst_flush", flush, 1);
      chk("post_rst_redir", redirect_pc, 32'h700);
      chk("post_rst_hit", pred_hit, 1);
      chk("post_rst_bcnt", branch_cnt, 1);

      // Saturation of both statistics counters
      for (int i = 0; i < 20; i++) begin
         set_ex(1'b1, 32'h10, 1'b1, 32'h20, 1'b0, 32'h14);
         @(posedge clk); #1;
      end
      chk("sat_mcnt", mispred_cnt, CMAX);
      chk("sat_bcnt", branch_cnt, CMAX);
      chk("sat_flush", flush, 1);

      // Randomized run against the reference model
      set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      #1 rst = 1'b1;
      #1 rst = 1'b0;
      m_reset();
      for (int n = 0; n < 400; n++) begin
         if_pc     = gen_pc();
         ex_valid  = ($urandom_range(0, 3) != 0);
         ex_pc     = gen_pc();
         ex_taken  = $urandom_range(0, 1);
         ex_target = gen_pc();
         if ($urandom_range(0, 1) != 0) begin
            m_look(ex_pc, h, t, tg);
            ex_pred_taken = t; ex_pred_target = tg;
         end else begin
            ex_pred_taken = $urandom_range(0, 1); ex_pred_target = gen_pc();
         end
         #1;
         m_look(if_pc, h, t, tg);
         chk("rnd_hit", pred_hit, h);
         chk("rnd_ptaken", pred_taken, t);
         chk("rnd_ptarget", pred_target, tg);
         m_step();
         @(posedge clk); #1;
         chk("rnd_flush", flush, m_flush);
         chk("rnd_redir", redirect_pc, m_redir);
         chk("rnd_bcnt", branch_cnt, m_bc);
         chk("rnd_mcnt", mispred_cnt, m_mc);
      end

      $display("[TB] %0d tests run, %0d failed", tests, errs);
      $finish;
   end

endmodule

// File: doc/bp_btb.md
Name: bp_btb

Overview:
- PC-indexed branch target buffer. Each entry holds a valid bit, a tag, a target and a 2-bit direction counter.
- Sits in IF: supplies the predicted direction and next-fetch PC each cycle.
- Consumes resolved branch outcomes from EX, updates its entries, and raises a registered flush/redirect on a misprediction.
- The counter update rule matches the team's 2-bit predictor FSM, so the per-branch predictor and this table stay behaviourally identical.

Parameters:
- XLEN, 32, PC/target width.
- ENTRIES, 16, number of entries; power of 2, at least 2.
- IDX_W, $clog2(ENTRIES), index width (derived; do not override).
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- if_pc  in  XLEN  fetch PC.
- pred_hit  out  1  lookup hit (valid and tag match).
- pred_taken  out  1  predicted taken.
- pred_target  out  XLEN  predicted next PC.
- ex_valid  in  1  resolved control-flow instruction present in EX.
- ex_pc  in  XLEN  PC of that instruction.
- ex_taken  in  1  actual outcome.
- ex_target  in  XLEN  actual taken target.
- ex_pred_taken  in  1  prediction that travelled down the pipe with the instruction.
- ex_pred_target  in  XLEN  predicted next PC that travelled with it.
- flush  out  1  mispredict: kill IF/ID/EX-younger instructions.
- redirect_pc  out  XLEN  correct next PC, valid while flush=1.
- branch_cnt  out  CNT_W  resolved branches counted.
- mispred_cnt  out  CNT_W  mispredictions counted.

Behaviour:
- Address split:
  - idx = pc[IDX_W+1:2].
  - tag = pc[XLEN-1:IDX_W+2].
  - pc[1:0] is ignored.
- Lookup (combinational from if_pc and the stored array):
  - hit = valid[idx] && tag[idx]==tag(if_pc).
  - pred_taken = hit && cnt[idx][1].
  - pred_target = pred_taken ? target[idx] : if_pc+4, computed modulo 2^XLEN (wraps).
- Counter encoding: 00 SNT, 01 WNT, 10 WT, 11 ST.
  - Taken: SNT→WNT, WNT→ST, WT→ST, ST→ST.
  - Not taken: SNT→SNT, WNT→SNT, WT→SNT, ST→WT.
- Update occurs on the clk edge when ex_valid=1, on entry u=idx(ex_pc):
  - Hit, any outcome: advance cnt[u] per the table above. If ex_taken=1, also write target[u]=ex_target.
  - Miss and ex_taken=1: allocate the entry (overwrite any occupant): valid=1, tag=tag(ex_pc), target=ex_target, cnt=WNT.
  - Miss and ex_taken=0: no change to the array.
- Read/write ordering:
  - An update is visible to lookups from the next cycle.
  - A same-cycle lookup of the same index returns the pre-update contents; there is no bypass.
- Mispredict detection (EX-stage, combinational):
  - mis = ex_valid && ((ex_pred_taken != ex_taken) || (ex_taken && ex_pred_target != ex_target)).
- Registered flush:
  - On the next edge: flush <= mis.
  - redirect_pc <= ex_taken ? ex_target : ex_pc+4.
  - redirect_pc holds its value when mis=0.
  - Latency is exactly 1 cycle after EX.
  - flush is a 1-cycle pulse per mispredicting instruction; back-to-back mispredicts give consecutive pulses.
- Statistics:
  - branch_cnt increments on ex_valid.
  - mispred_cnt increments on mis.
  - Both saturate at all-ones and do not wrap.
- Reset (async, effective immediately):
  - All valid bits=0, all counters=SNT, targets=0.
  - flush=0, redirect_pc=0, branch_cnt=0, mispred_cnt=0.
  - Resulting outputs: pred_hit=0, pred_taken=0, pred_target=if_pc+4.
  - Reset asserted mid-operation discards any pending update or flush. The first edge after deassertion performs a normal update if ex_valid=1.
- Simultaneous events:
  - A lookup and an update in the same cycle are independent (see ordering above).
  - Alias: two PCs with the same idx and different tags; the later allocation evicts the earlier.
  - No X propagation: untouched targets read 0 after reset.

Test Plan:
- Reset, then if_pc=0x100 → pred_hit=0, pred_taken=0, pred_target=0x104; flush=0; both counters 0.
- Miss, taken: ex_valid=1, ex_pc=0x100, ex_taken=1, ex_target=0x200, ex_pred_taken=0.
  - Next cycle: flush=1, redirect_pc=0x200, mispred_cnt=1.
  - if_pc=0x100 → hit=1, cnt=WNT, pred_taken=0.
  - A second taken resolve → ST, pred_taken=1, pred_target=0x200.
- Counter walk on idx of 0x100, starting from ST: not-taken→WT (pred 1), not-taken→SNT (pred 0), taken→WNT, taken→ST. Check pred_taken after each edge.
- Alias eviction, ENTRIES=16: allocate 0x100, then allocate 0x140 (same idx 0, different tag) taken → lookup of 0x100 gives hit=0.
- Target mismatch: hit ST entry, ex_pred_taken=1, ex_pred_target=0x200, ex_target=0x300, ex_taken=1 → flush=1, redirect_pc=0x300, stored target=0x300.
- Predicted taken but not taken: ex_pred_taken=1, ex_taken=0, ex_pc=0xFFFFFFFC → redirect_pc=0x0 (wrap).
- Saturation: with CNT_W=4, 20 mispredicts → mispred_cnt=15.
- Async rst pulse mid-stream → all outputs to reset values without a clock edge.
